seq_det_sched: RTL and testbench
================================

SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 Parameter BITS, default 8: byte width serialized per request.
REQ-002 Parameter IDX_W, default 3: width of hit index, equal to clog2(BITS).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req0_valid  in  1  requester 0 has a byte.
REQ-006 req0_data  in  BITS  requester 0 byte.
REQ-007 req0_ready  out  1  requester 0 byte accepted this cycle when valid.
REQ-008 req1_valid / req1_data / req1_ready  same as REQ-005..007 for requester 1.
REQ-009 det_clr  out  1  clear pulse to the shared sequence detector.
REQ-010 det_in  out  1  serial bit to the detector.
REQ-011 det_out  in  1  detector registered output; reflects the bit presented the previous cycle.
REQ-012 rsp_valid  out  1  result available.
REQ-013 rsp_ready  in  1  result consumer ready.
REQ-014 rsp_id  out  1  requester that owns the result.
REQ-015 rsp_hit  out  1  det_out seen high for at least one bit of the byte.
REQ-016 rsp_idx  out  IDX_W  index of first bit (LSB = 0) whose sample was high; 0 when rsp_hit = 0.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, CLR, SHIFT, DRAIN, RESP; one-hot or binary encoding is implementation choice.
REQ-019 IDLE: grant computed combinationally; reqN_ready = 1 only for the granted requester with reqN_valid = 1; the other ready = 0.
REQ-020 Arbitration round-robin: both valid -> grant the requester not granted last; one valid -> grant it; last_grant resets to 1 so requester 0 wins first tie.
REQ-021 On handshake (valid && ready) capture data, owner id, update last_grant, go to CLR.
REQ-022 CLR: det_clr = 1 for exactly one cycle, det_in = 0; next SHIFT with bit counter = 0.
REQ-023 SHIFT: det_in = data[counter], LSB first, BITS cycles; counter increments each cycle; after counter = BITS-1 go to DRAIN.
REQ-024 Sampling: det_out sampled in each SHIFT cycle with counter >= 1 (attributed to bit counter-1) and in DRAIN (attributed to bit BITS-1); det_out during first SHIFT cycle ignored.
REQ-025 First high sample sets hit flag and records its bit index; later high samples do not change the index.
REQ-026 DRAIN lasts one cycle, det_in = 0, then RESP.
REQ-027 RESP: rsp_valid = 1 with rsp_id, rsp_hit, rsp_idx stable until rsp_valid && rsp_ready; then IDLE next cycle.
REQ-028 Latency: handshake in cycle T -> CLR at T+1, SHIFT T+2..T+BITS+1, DRAIN T+BITS+2, rsp_valid first high at T+BITS+3 (T+11 for BITS = 8).
REQ-029 No new request accepted outside IDLE; both readys = 0 in CLR, SHIFT, DRAIN, RESP; requester valids held across non-IDLE cycles are not lost.
REQ-030 Minimum one IDLE cycle between consecutive jobs; peak throughput one byte per BITS+4 cycles.
REQ-031 rsp_ready high before RESP has no effect.

Reset
REQ-032 Reset high forces IDLE immediately: busy, rsp_valid, rsp_hit, rsp_id, det_clr, det_in, req0_ready, req1_ready = 0, rsp_idx = 0, counter = 0, last_grant = 1.
REQ-033 Reset asserted mid-SHIFT or in RESP discards the job; no response produced after release.
REQ-034 After reset release, the first accepted job starts with a CLR pulse as in REQ-022.

Verification
REQ-035 Bench detector model: out = 1 after four consecutive equal inputs, cleared by det_clr.
REQ-036 req0 0x0F alone -> req0_ready high in accept cycle, det_clr pulse at T+1, rsp_valid at T+11 with id 0, hit 1, idx 3.
REQ-037 req1 0x55 alone -> id 1, hit 0, idx 0.
REQ-038 Both valid continuously after reset (0xF0, 0x0F) -> grants 0,1,0,1; each rsp held until rsp_ready; no overlap of jobs.
REQ-039 rsp_ready held low 20 cycles in RESP -> outputs stable, both readys 0, no new CLR pulse.
REQ-040 Reset pulsed at T+5 of a job -> all outputs 0 same cycle; no rsp_valid afterward until a new handshake.

Source files
------------

// File: rtl/seq_det_sched.sv
// rtl/seq_det_sched.sv - round-robin byte scheduler feeding a shared serial sequence detector
module seq_det_sched #(
  parameter int BITS  = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [BITS-1:0]  req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [BITS-1:0]  req1_data,
  output logic             req1_ready,
  output logic             det_clr,
  output logic             det_in,
  input  logic             det_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_idx,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_DRAIN,
    S_RESP
  } state_t;

  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(BITS - 1);

  state_t           state;
  logic [BITS-1:0]  data_q;
  logic             owner_q;
  logic             last_grant;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_nxt;
  logic             hit_q;
  logic [IDX_W-1:0] idx_q;
  logic             grant;
  logic             accept;

  // Round-robin pick: on a tie the requester not served last wins; ready only offered in IDLE
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (!req0_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = !reset && (state == S_IDLE) && req0_valid && !grant;
  assign req1_ready = !reset && (state == S_IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign cnt_nxt    = cnt + 1'b1;

  // Job sequencer: accept, clear detector, shift bits LSB first, collect the trailing sample, respond
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      data_q     <= '0;
      owner_q    <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      hit_q      <= 1'b0;
      idx_q      <= '0;
      det_clr    <= 1'b0;
      det_in     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_idx    <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            data_q     <= grant ? req1_data : req0_data;
            owner_q    <= grant;
            last_grant <= grant;
            hit_q      <= 1'b0;
            idx_q      <= '0;
            cnt        <= '0;
            det_clr    <= 1'b1;
            det_in     <= 1'b0;
            busy       <= 1'b1;
            state      <= S_CLR;
          end
        end
        S_CLR: begin
          det_clr <= 1'b0;
          det_in  <= data_q[0];
          cnt     <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          // det_out lags det_in by one cycle, so the sample now belongs to bit cnt-1
          if ((cnt != '0) && det_out && !hit_q) begin
            hit_q <= 1'b1;
            idx_q <= cnt - 1'b1;
          end
          if (cnt == LAST_BIT) begin
            det_in <= 1'b0;
            cnt    <= '0;
            state  <= S_DRAIN;
          end else begin
            det_in <= data_q[cnt_nxt];
            cnt    <= cnt_nxt;
          end
        end
        S_DRAIN: begin
          // Last sample belongs to the top bit; an earlier hit keeps its index
          rsp_valid <= 1'b1;
          rsp_id    <= owner_q;
          rsp_hit   <= hit_q || det_out;
          if (hit_q) begin
            rsp_idx <= idx_q;
          end else if (det_out) begin
            rsp_idx <= LAST_BIT;
          end else begin
            rsp_idx <= '0;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_idx   <= '0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// tb/tb_seq_det_sched.sv - self-checking bench for seq_det_sched
module tb_seq_det_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       det_clr, det_in, det_out;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_hit;
  logic [2:0] rsp_idx;
  logic       busy;

  seq_det_sched #(.BITS(8), .IDX_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_clr(det_clr), .det_in(det_in), .det_out(det_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_hit(rsp_hit), .rsp_idx(rsp_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cyc = -100;
  bit prev_rv = 1'b0;

  typedef struct packed {
    logic       id;
    logic       hit;
    logic [2:0] idx;
  } rsp_t;
  rsp_t sb[$];

  typedef struct {
    bit         v0;
    bit         v1;
    logic [7:0] d0;
    logic [7:0] d1;
    rsp_t       exp;
    int         delay;
    bit         early;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Detector model: high after four consecutive equal inputs, cleared by det_clr
  int  m_run;
  int  m_r;
  logic m_last;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      det_out <= 1'b0;
      m_run   <= 0;
      m_last  <= 1'b0;
    end else if (det_clr) begin
      det_out <= 1'b0;
      m_run   <= 0;
    end else begin
      m_r = (m_run == 0 || det_in != m_last) ? 1 : m_run + 1;
      if (m_r > 4) m_r = 4;
      m_run   <= m_r;
      m_last  <= det_in;
      det_out <= (m_r >= 4);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: latency, no acceptance while busy, scoreboard pop on response handshake
  always @(negedge clk) begin
    if (!reset) begin
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) hs_cyc = cyc;
      if (det_clr) chk("clr_latency", cyc - hs_cyc, 1);
      if (rsp_valid && !prev_rv) chk("rsp_latency", cyc - hs_cyc, 11);
      if (busy) chk("ready_while_busy", {req0_ready, req1_ready}, 0);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_hit", rsp_hit, e.hit);
          chk("rsp_idx", rsp_idx, e.idx);
        end
      end
    end
    prev_rv = rsp_valid;
  end

  task automatic wait_hs();
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("hs_timeout", 0, 1);
  endtask

  task automatic wait_rsp();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 0, 1);
  endtask

  task automatic hold_check(input int n);
    logic [4:0] snap;
    snap = {rsp_id, rsp_hit, rsp_idx};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_stable", {rsp_id, rsp_hit, rsp_idx}, snap);
      chk("hold_no_clr", det_clr, 0);
      chk("hold_readys", {req0_ready, req1_ready}, 0);
    end
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    @(posedge clk); #1;
    req0_valid = v.v0; req0_data = v.d0;
    req1_valid = v.v1; req1_data = v.d1;
    if (v.early) rsp_ready = 1'b1;
    sb.push_back(v.exp);
    wait_hs();
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp();
    if (v.early) begin
      @(posedge clk); #1;
      rsp_ready = 1'b0;
    end else begin
      hold_check(v.delay);
      pulse_ready();
    end
    @(negedge clk);
    chk("rsp_released", rsp_valid, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrv;
    tbl[0] = '{1'b1, 1'b0, 8'h0F, 8'h00, '{1'b0, 1'b1, 3'd3}, 2, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h55, '{1'b1, 1'b0, 3'd0}, 0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'hFF, 8'h00, '{1'b0, 1'b1, 3'd3}, 0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h00, '{1'b1, 1'b1, 3'd3}, 1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 8'hF5, 8'h33, '{1'b0, 1'b1, 3'd7}, 3, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 8'h33, 8'h87, '{1'b1, 1'b1, 3'd6}, 0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 8'h33, 8'h00, '{1'b0, 1'b0, 3'd0}, 1, 1'b0};

    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'hA5;
    req1_valid = 1'b1; req1_data = 8'h5A;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_id, rsp_hit, rsp_idx}, 0);
    chk("rst_det", {det_clr, det_in}, 0);
    chk("rst_readys", {req0_ready, req1_ready}, 0);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (tbl[i]) run_job(tbl[i]);

    // Response held for 20 cycles while requester 1 waits; its request must survive
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h0F;
    sb.push_back('{1'b0, 1'b1, 3'd3});
    wait_hs();
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp();
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_data = 8'h55;
    sb.push_back('{1'b1, 1'b0, 3'd0});
    hold_check(20);
    pulse_ready();
    wait_hs();
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp();
    pulse_ready();

    // Both valid continuously from reset: grants alternate 0,1,0,1
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hF0;
    req1_valid = 1'b1; req1_data = 8'h0F;
    for (int k = 0; k < 4; k++) sb.push_back('{k[0], 1'b1, 3'd3});
    for (int k = 0; k < 4; k++) begin
      wait_rsp();
      hold_check(2);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      if (k == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    chk("rr_idle_after", busy, 0);

    // Reset in the middle of SHIFT discards the job
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'h0F;
    sb.push_back('{1'b0, 1'b1, 3'd3});
    wait_hs();
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_det", {det_clr, det_in}, 0);
    chk("midrst_rsp", {rsp_valid, rsp_id, rsp_hit, rsp_idx}, 0);
    chk("midrst_readys", {req0_ready, req1_ready}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    nrv = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid) nrv++;
    end
    chk("midrst_no_rsp", nrv, 0);
    run_job(tbl[0]);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
